led_chain_driver: RTL and testbench

//  Next-generation serial LED driver. Streams a frame of c_channels words per lane out of frame memory.

---
 rtl/led_chain_driver_pkg.sv | 14 +
 rtl/led_addr_map.sv | 18 +
 rtl/led_chain_driver.sv | 216 +++++++++++++++++++++
 tb/tb_led_chain_driver.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_chain_driver_pkg.sv
// Shared types and defaults for the serial LED chain driver and its address map.
package led_chain_driver_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SHIFT = 3'd2,
      S_LATCH = 3'd3
   } state_t;

   localparam int unsigned C_BPC_DEFAULT   = 12;
   localparam int unsigned C_GROUP_DEFAULT = 16;

endpackage

// File: rtl/led_addr_map.sv
// Frame-memory index to address map; optionally reverses word order inside each group.
module led_addr_map
   import led_chain_driver_pkg::*;
#(
   parameter int unsigned c_addr_w  = 10,
   parameter int unsigned c_group   = C_GROUP_DEFAULT,
   parameter int unsigned c_reverse = 1
) (
   input  logic [c_addr_w-1:0] idx,
   output logic [c_addr_w-1:0] addr_c
);

   // Group is a power of two, so inverting the low bits is an XOR with group-1.
   localparam logic [c_addr_w-1:0] c_mask = (c_reverse != 0) ? c_addr_w'(c_group - 1) : '0;

   assign addr_c = idx ^ c_mask;

endmodule

// File: rtl/led_chain_driver.sv
// Streams one frame per lane from frame memory onto parallel LED daisy chains
// with a shared divided SCLK and latch pulse.
module led_chain_driver
   import led_chain_driver_pkg::*;
#(
   parameter int unsigned c_lanes        = 2,
   parameter int unsigned c_channels     = 960,
   parameter int unsigned c_bpc          = C_BPC_DEFAULT,
   parameter int unsigned c_group        = C_GROUP_DEFAULT,
   parameter int unsigned c_reverse      = 1,
   parameter int unsigned c_sclk_half    = 1,
   parameter int unsigned c_rd_lat       = 1,
   parameter int unsigned c_lat_cycles   = 2,
   parameter int unsigned c_frame_period = 16666,
   parameter int unsigned c_ext_sync     = 0,
   parameter int unsigned c_addr_w       = $clog2(c_channels)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_enable,
   input  logic                       i_sync,
   input  logic [c_lanes*c_bpc-1:0]   i_data,
   output logic [c_addr_w-1:0]        o_addr,
   output logic                       o_sclk,
   output logic [c_lanes-1:0]         o_dai,
   output logic                       o_lat,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overrun
);

   localparam int unsigned c_tick_w = (c_frame_period > 1) ? $clog2(c_frame_period) : 1;
   localparam int unsigned c_half_w = $clog2(c_sclk_half + 1);
   localparam int unsigned c_bit_w  = $clog2(c_bpc + 1);
   localparam int unsigned c_rd_w   = $clog2(c_rd_lat + 1);
   localparam int unsigned c_lat_w  = $clog2(c_lat_cycles + 1);

   state_t                state_q, state_d;
   logic [c_addr_w-1:0]   idx_q, idx_d, nxt_idx_c, map_c, addr_d;
   logic [c_rd_w-1:0]     rd_q, rd_d;
   logic [c_half_w-1:0]   half_q, half_d;
   logic [c_bit_w-1:0]    bit_q, bit_d;
   logic [c_lat_w-1:0]    latc_q, latc_d;
   logic [c_tick_w-1:0]   tick_q;
   logic                  phase_q, phase_d;
   logic                  sync_q, ext_start_q, start_c;
   logic                  sclk_d, lat_d, busy_d, done_d, overrun_d;
   logic                  load_c, shift_c, clr_c;

   // Free-running frame tick and registered external sync edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tick_q      <= '0;
         sync_q      <= 1'b0;
         ext_start_q <= 1'b0;
      end else begin
         tick_q      <= (tick_q == c_tick_w'(c_frame_period - 1)) ? '0 : tick_q + c_tick_w'(1);
         sync_q      <= i_sync;
         ext_start_q <= i_sync & ~sync_q;
      end
   end

   assign start_c   = (c_ext_sync != 0) ? ext_start_q : (tick_q == '0);
   assign nxt_idx_c = (state_q == S_IDLE) ? '0 : idx_q + c_addr_w'(1);

   led_addr_map #(
      .c_addr_w  (c_addr_w),
      .c_group   (c_group),
      .c_reverse (c_reverse)
   ) u_addr_map (
      .idx    (nxt_idx_c),
      .addr_c (map_c)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         rd_q      <= '0;
         half_q    <= '0;
         bit_q     <= '0;
         latc_q    <= '0;
         phase_q   <= 1'b0;
         o_addr    <= '0;
         o_sclk    <= 1'b0;
         o_lat     <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_q      <= rd_d;
         half_q    <= half_d;
         bit_q     <= bit_d;
         latc_q    <= latc_d;
         phase_q   <= phase_d;
         o_addr    <= addr_d;
         o_sclk    <= sclk_d;
         o_lat     <= lat_d;
         o_busy    <= busy_d;
         o_done    <= done_d;
         o_overrun <= overrun_d;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_d      = rd_q;
      half_d    = half_q;
      bit_d     = bit_q;
      latc_d    = latc_q;
      phase_d   = phase_q;
      addr_d    = o_addr;
      sclk_d    = 1'b0;
      lat_d     = 1'b0;
      busy_d    = o_busy;
      done_d    = 1'b0;
      overrun_d = start_c && (state_q != S_IDLE);
      load_c    = 1'b0;
      shift_c   = 1'b0;
      clr_c     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start_c && i_enable) begin
               state_d = S_FETCH;
               idx_d   = nxt_idx_c;
               rd_d    = '0;
               addr_d  = map_c;
               busy_d  = 1'b1;
            end
         end
         S_FETCH: begin
            if (rd_q == c_rd_w'(c_rd_lat - 1)) begin
               state_d = S_SHIFT;
               half_d  = '0;
               phase_d = 1'b0;
               bit_d   = '0;
               load_c  = 1'b1;
            end else begin
               rd_d = rd_q + c_rd_w'(1);
            end
         end
         S_SHIFT: begin
            if (half_q == c_half_w'(c_sclk_half - 1)) begin
               half_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  sclk_d  = 1'b1;
               end else if (bit_q != c_bit_w'(c_bpc - 1)) begin
                  phase_d = 1'b0;
                  bit_d   = bit_q + c_bit_w'(1);
                  shift_c = 1'b1;
               end else if (idx_q == c_addr_w'(c_channels - 1)) begin
                  state_d = S_LATCH;
                  latc_d  = '0;
                  lat_d   = 1'b1;
                  clr_c   = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  idx_d   = nxt_idx_c;
                  rd_d    = '0;
                  addr_d  = map_c;
               end
            end else begin
               half_d = half_q + c_half_w'(1);
               sclk_d = o_sclk;
            end
         end
         S_LATCH: begin
            // Latch high for c_lat_cycles, then one done cycle that still counts as busy.
            if (latc_q == c_lat_w'(c_lat_cycles)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (latc_q == c_lat_w'(c_lat_cycles - 1)) begin
               done_d = 1'b1;
               latc_d = latc_q + c_lat_w'(1);
            end else begin
               lat_d  = 1'b1;
               latc_d = latc_q + c_lat_w'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Per-lane shift register; o_dai updates only at the start of a low phase.
   for (genvar l = 0; l < c_lanes; l++) begin : g_lane
      logic [c_bpc-1:0] word_c;
      logic [c_bpc-1:0] shreg_q;
      logic             dai_q;

      assign word_c = i_data[l*c_bpc +: c_bpc];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            shreg_q <= '0;
            dai_q   <= 1'b0;
         end else if (load_c) begin
            shreg_q <= word_c;
            dai_q   <= word_c[c_bpc-1];
         end else if (shift_c) begin
            shreg_q <= {shreg_q[c_bpc-2:0], 1'b0};
            dai_q   <= shreg_q[c_bpc-2];
         end else if (clr_c) begin
            dai_q   <= 1'b0;
         end
      end

      assign o_dai[l] = dai_q;
   end

endmodule

// File: tb/tb_led_chain_driver.sv
// Directed bench: four driver instances with different modes share one clock.
module tb_led_chain_driver;

   logic       clk = 1'b0;
   logic [3:0] rst_n = 4'b0000;
   logic [3:0] en = 4'b1111;
   logic       sync_c = 1'b0;

   logic [1:0] addr_w [4];
   logic [1:0] dai_w  [4];
   logic [7:0] data_w [4];
   logic [3:0] sclk_w, lat_w, busy_w, done_w, ovr_w;
   logic [1:0] ap1, ap2;

   int tests = 0;
   int fails = 0;

   int         rises  [4] = '{default: 0};
   int         lat_n  [4] = '{default: 0};
   int         done_n [4] = '{default: 0};
   int         busy_n [4] = '{default: 0};
   int         ovr_n  [4] = '{default: 0};
   int         lowrun [4] = '{default: 0};
   int         maxlow [4] = '{default: 0};
   logic [15:0] bits0 [4] = '{default: '0};
   logic [15:0] bits1 [4] = '{default: '0};
   logic [7:0]  addrseq [4] = '{default: '0};
   logic [3:0]  psclk = 4'b0000;

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_word(input logic [1:0] a);
      logic [3:0] lo;
      lo = {2'b00, a};
      return {lo | 4'b1000, lo};
   endfunction

   assign data_w[0] = mem_word(addr_w[0]);
   assign data_w[1] = mem_word(addr_w[1]);
   assign data_w[2] = mem_word(addr_w[2]);
   assign data_w[3] = mem_word(ap2);

   // Three-cycle read port for the slow-fetch instance.
   always @(posedge clk) begin
      ap1 <= addr_w[3];
      ap2 <= ap1;
   end

   led_chain_driver #(.c_lanes(2), .c_channels(4), .c_bpc(4), .c_group(4), .c_reverse(1),
      .c_sclk_half(2), .c_rd_lat(1), .c_lat_cycles(2), .c_frame_period(200), .c_ext_sync(0))
   u_a (.i_clk(clk), .i_rst_n(rst_n[0]), .i_enable(en[0]), .i_sync(1'b0), .i_data(data_w[0]),
      .o_addr(addr_w[0]), .o_sclk(sclk_w[0]), .o_dai(dai_w[0]), .o_lat(lat_w[0]),
      .o_busy(busy_w[0]), .o_done(done_w[0]), .o_overrun(ovr_w[0]));

   led_chain_driver #(.c_lanes(2), .c_channels(4), .c_bpc(4), .c_group(4), .c_reverse(0),
      .c_sclk_half(2), .c_rd_lat(1), .c_lat_cycles(2), .c_frame_period(200), .c_ext_sync(0))
   u_b (.i_clk(clk), .i_rst_n(rst_n[1]), .i_enable(en[1]), .i_sync(1'b0), .i_data(data_w[1]),
      .o_addr(addr_w[1]), .o_sclk(sclk_w[1]), .o_dai(dai_w[1]), .o_lat(lat_w[1]),
      .o_busy(busy_w[1]), .o_done(done_w[1]), .o_overrun(ovr_w[1]));

   led_chain_driver #(.c_lanes(2), .c_channels(4), .c_bpc(4), .c_group(4), .c_reverse(1),
      .c_sclk_half(2), .c_rd_lat(1), .c_lat_cycles(2), .c_frame_period(200), .c_ext_sync(1))
   u_c (.i_clk(clk), .i_rst_n(rst_n[2]), .i_enable(en[2]), .i_sync(sync_c), .i_data(data_w[2]),
      .o_addr(addr_w[2]), .o_sclk(sclk_w[2]), .o_dai(dai_w[2]), .o_lat(lat_w[2]),
      .o_busy(busy_w[2]), .o_done(done_w[2]), .o_overrun(ovr_w[2]));

   led_chain_driver #(.c_lanes(2), .c_channels(4), .c_bpc(4), .c_group(4), .c_reverse(1),
      .c_sclk_half(1), .c_rd_lat(3), .c_lat_cycles(2), .c_frame_period(200), .c_ext_sync(0))
   u_d (.i_clk(clk), .i_rst_n(rst_n[3]), .i_enable(en[3]), .i_sync(1'b0), .i_data(data_w[3]),
      .o_addr(addr_w[3]), .o_sclk(sclk_w[3]), .o_dai(dai_w[3]), .o_lat(lat_w[3]),
      .o_busy(busy_w[3]), .o_done(done_w[3]), .o_overrun(ovr_w[3]));

   // Observer: records bits and address on SCLK rises, and counts status cycles.
   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (sclk_w[d] && !psclk[d]) begin
            if (rises[d] % 4 == 0) addrseq[d] <= {addrseq[d][5:0], addr_w[d]};
            bits0[d] <= {bits0[d][14:0], dai_w[d][0]};
            bits1[d] <= {bits1[d][14:0], dai_w[d][1]};
            rises[d] <= rises[d] + 1;
         end
         if (lat_w[d])  lat_n[d]  <= lat_n[d] + 1;
         if (done_w[d]) done_n[d] <= done_n[d] + 1;
         if (busy_w[d]) busy_n[d] <= busy_n[d] + 1;
         if (ovr_w[d])  ovr_n[d]  <= ovr_n[d] + 1;
         if (busy_w[d] && !sclk_w[d] && !lat_w[d] && !done_w[d]) begin
            lowrun[d] <= lowrun[d] + 1;
            if (lowrun[d] + 1 > maxlow[d]) maxlow[d] <= lowrun[d] + 1;
         end else begin
            lowrun[d] <= 0;
         end
      end
      psclk <= sclk_w;
   end

   task automatic wait_done(input int d, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_n[d] >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_busy(input int d, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy_w[d]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         tests++;
         if ({addr_w[d], dai_w[d], sclk_w[d], lat_w[d], busy_w[d], done_w[d], ovr_w[d]} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs dut%0d: got %b expected 0", d,
               {addr_w[d], dai_w[d], sclk_w[d], lat_w[d], busy_w[d], done_w[d], ovr_w[d]});
         end
      end
   endtask

   task automatic test_frame_reverse();
      bit ok;
      int l0, d0, b0, r0, o0;
      l0 = lat_n[0]; d0 = done_n[0]; b0 = busy_n[0]; r0 = rises[0]; o0 = ovr_n[0];
      rst_n[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (busy_w[0] !== 1'b1) begin
         fails++; $display("FAIL start_latency: busy=%b expected 1", busy_w[0]);
      end
      wait_done(0, d0 + 1, 200, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL frame1_timeout: no o_done within 200 cycles"); end
      repeat (2) @(negedge clk);
      tests++;
      if (addrseq[0] !== 8'hE4) begin
         fails++; $display("FAIL rev_addr_order: got %h expected e4", addrseq[0]);
      end
      tests++;
      if (bits0[0] !== 16'h3210 || bits1[0] !== 16'hBA98) begin
         fails++; $display("FAIL rev_data: lane0=%h lane1=%h expected 3210 ba98", bits0[0], bits1[0]);
      end
      tests++;
      if (rises[0] - r0 != 16) begin
         fails++; $display("FAIL sclk_rises: got %0d expected 16", rises[0] - r0);
      end
      tests++;
      if (lat_n[0] - l0 != 2 || done_n[0] - d0 != 1 || ovr_n[0] - o0 != 0) begin
         fails++; $display("FAIL latch_done: lat=%0d done=%0d ovr=%0d expected 2 1 0",
            lat_n[0] - l0, done_n[0] - d0, ovr_n[0] - o0);
      end
      tests++;
      if (busy_n[0] - b0 != 71) begin
         fails++; $display("FAIL frame_len: got %0d expected 71", busy_n[0] - b0);
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      int l0, d0, b0;
      l0 = lat_n[0]; d0 = done_n[0]; b0 = busy_n[0];
      wait_busy(0, 250, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL tick_start_timeout: no frame within 250 cycles"); end
      repeat (29) @(negedge clk);
      en[0] = 1'b0;
      repeat (650) @(negedge clk);
      tests++;
      if (done_n[0] - d0 != 1 || lat_n[0] - l0 != 2) begin
         fails++; $display("FAIL enable_drop_done: done=%0d lat=%0d expected 1 2",
            done_n[0] - d0, lat_n[0] - l0);
      end
      tests++;
      if (busy_n[0] - b0 != 71) begin
         fails++; $display("FAIL enable_drop_frames: busy=%0d expected 71", busy_n[0] - b0);
      end
      tests++;
      if (bits0[0] !== 16'h3210) begin
         fails++; $display("FAIL enable_drop_data: got %h expected 3210", bits0[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int l0, d0, b0;
      en[0] = 1'b1;
      l0 = lat_n[0]; d0 = done_n[0];
      wait_busy(0, 250, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rst_start_timeout: no frame within 250 cycles"); end
      repeat (39) @(negedge clk);
      #2 rst_n[0] = 1'b0;
      #1;
      tests++;
      if ({addr_w[0], dai_w[0], sclk_w[0], lat_w[0], busy_w[0], done_w[0], ovr_w[0]} !== 9'd0) begin
         fails++; $display("FAIL async_reset: got %b expected 0",
            {addr_w[0], dai_w[0], sclk_w[0], lat_w[0], busy_w[0], done_w[0], ovr_w[0]});
      end
      repeat (3) @(negedge clk);
      tests++;
      if (lat_n[0] - l0 != 0 || done_n[0] - d0 != 0) begin
         fails++; $display("FAIL no_latch_on_reset: lat=%0d done=%0d expected 0 0",
            lat_n[0] - l0, done_n[0] - d0);
      end
      l0 = lat_n[0]; d0 = done_n[0]; b0 = busy_n[0];
      rst_n[0] = 1'b1;
      wait_done(0, d0 + 1, 200, ok);
      repeat (2) @(negedge clk);
      tests++;
      if (!ok || busy_n[0] - b0 != 71 || lat_n[0] - l0 != 2) begin
         fails++; $display("FAIL post_reset_frame: ok=%0d busy=%0d lat=%0d expected 1 71 2",
            ok, busy_n[0] - b0, lat_n[0] - l0);
      end
      tests++;
      if (bits0[0] !== 16'h3210 || bits1[0] !== 16'hBA98) begin
         fails++; $display("FAIL post_reset_data: lane0=%h lane1=%h expected 3210 ba98",
            bits0[0], bits1[0]);
      end
   endtask

   task automatic test_linear();
      bit ok;
      int b0;
      b0 = busy_n[1];
      rst_n[1] = 1'b1;
      wait_done(1, 1, 200, ok);
      repeat (2) @(negedge clk);
      tests++;
      if (!ok || addrseq[1] !== 8'h1B) begin
         fails++; $display("FAIL lin_addr_order: ok=%0d got %h expected 1b", ok, addrseq[1]);
      end
      tests++;
      if (bits0[1] !== 16'h0123 || bits1[1] !== 16'h89AB) begin
         fails++; $display("FAIL lin_data: lane0=%h lane1=%h expected 0123 89ab", bits0[1], bits1[1]);
      end
      tests++;
      if (busy_n[1] - b0 != 71) begin
         fails++; $display("FAIL lin_frame_len: got %0d expected 71", busy_n[1] - b0);
      end
   endtask

   task automatic test_ext_sync();
      bit ok;
      int b0, d0, o0;
      b0 = busy_n[2]; d0 = done_n[2]; o0 = ovr_n[2];
      rst_n[2] = 1'b1;
      repeat (20) @(negedge clk);
      tests++;
      if (busy_n[2] - b0 != 0) begin
         fails++; $display("FAIL ext_ignores_tick: busy=%0d expected 0", busy_n[2] - b0);
      end
      sync_c = 1'b1;
      @(negedge clk);
      sync_c = 1'b0;
      repeat (30) @(negedge clk);
      tests++;
      if (busy_w[2] !== 1'b1) begin
         fails++; $display("FAIL ext_start: busy=%b expected 1", busy_w[2]);
      end
      sync_c = 1'b1;
      @(negedge clk);
      sync_c = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (ovr_n[2] - o0 != 1) begin
         fails++; $display("FAIL overrun_pulse: got %0d expected 1", ovr_n[2] - o0);
      end
      wait_done(2, d0 + 1, 200, ok);
      repeat (2) @(negedge clk);
      tests++;
      if (!ok || busy_n[2] - b0 != 71) begin
         fails++; $display("FAIL no_restart: ok=%0d busy=%0d expected 1 71", ok, busy_n[2] - b0);
      end
      repeat (3) @(negedge clk);
      sync_c = 1'b1;
      wait_done(2, d0 + 2, 200, ok);
      repeat (300) @(negedge clk);
      sync_c = 1'b0;
      tests++;
      if (!ok || done_n[2] - d0 != 2 || ovr_n[2] - o0 != 1) begin
         fails++; $display("FAIL sync_held_one_frame: ok=%0d done=%0d ovr=%0d expected 1 2 1",
            ok, done_n[2] - d0, ovr_n[2] - o0);
      end
      tests++;
      if (bits0[2] !== 16'h3210) begin
         fails++; $display("FAIL ext_data: got %h expected 3210", bits0[2]);
      end
   endtask

   task automatic test_slow_fetch();
      bit ok;
      int b0, r0;
      b0 = busy_n[3]; r0 = rises[3];
      rst_n[3] = 1'b1;
      wait_done(3, 1, 200, ok);
      repeat (2) @(negedge clk);
      tests++;
      if (!ok || busy_n[3] - b0 != 47) begin
         fails++; $display("FAIL slow_frame_len: ok=%0d got %0d expected 47", ok, busy_n[3] - b0);
      end
      tests++;
      if (bits0[3] !== 16'h3210 || bits1[3] !== 16'hBA98 || rises[3] - r0 != 16) begin
         fails++; $display("FAIL slow_data: lane0=%h lane1=%h rises=%0d expected 3210 ba98 16",
            bits0[3], bits1[3], rises[3] - r0);
      end
      // Gap before each word: three fetch cycles plus the one-cycle low phase.
      tests++;
      if (maxlow[3] != 4) begin
         fails++; $display("FAIL slow_sclk_gap: got %0d expected 4", maxlow[3]);
      end
   endtask

   initial begin
      test_reset();
      test_frame_reverse();
      test_enable_drop();
      test_reset_mid_frame();
      test_linear();
      test_ext_sync();
      test_slow_fetch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
